rare_event_window_monitor: RTL and testbench
============================================

Name: rare_event_window_monitor

Overview:
- Downstream consumer of a netlist subcircuit output (e.g. an I5334-style node) in the trojan-detection benchmarks.
- Counts rising transitions of that 1-bit net over fixed, back-to-back observation windows.
- Reports each window's count and raises a sticky alarm when a window exceeds a rarity threshold.
- Gives the bench a cycle-accurate trigger-activity signature per subcircuit.

Parameters:
- WINDOW, 16: cycles per observation window (>=2).
- CNT_W, 8: width of the rise counter and of last_count.
- THRESH, 3: the alarm sets when a window's count is strictly greater than THRESH.

Ports:
- I1470_clk  in  1  single clock; all state updates on its rising edge.
- I1477_rst  in  1  synchronous, active-high reset.
- sample_in  in  1  monitored subcircuit output net.
- enable  in  1  run request; low aborts the current window.
- alarm_clr  in  1  clears the sticky alarm.
- busy  out  1  high in ARM, COUNT or REPORT.
- window_done  out  1  one-cycle pulse, asserted in REPORT.
- last_count  out  CNT_W  rise count of the most recently completed window.
- alarm  out  1  sticky over-threshold flag.

Behaviour:
- Reset (I1477_rst=1 at an edge):
  - state=IDLE.
  - busy, window_done, alarm = 0; last_count = 0.
  - Rise counter, window counter, sample_q and sample_q_d all cleared.
  - Reset overrides every other input, including mid-window; a partial count is discarded.
- Input path:
  - sample_q <= sample_in every cycle; sample_q_d <= sample_q.
  - rise = sample_q & ~sample_q_d, so a 0->1 on sample_in is counted 2 edges later.
- FSM state IDLE:
  - enable=1 -> ARM. Otherwise stay in IDLE.
- FSM state ARM (one cycle):
  - Primes the edge detector; no counting.
  - Rise counter and window counter cleared.
  - -> COUNT if enable=1, else -> IDLE.
- FSM state COUNT:
  - Each cycle: the window counter increments; the rise counter increments on rise, saturating at 2^CNT_W-1 with no wrap.
  - After exactly WINDOW COUNT cycles (window counter == WINDOW-1, a rise on that cycle included) -> REPORT.
  - enable=0 in any COUNT cycle -> IDLE: counters cleared, no window_done, last_count unchanged.
- FSM state REPORT (one cycle):
  - window_done=1; last_count holds the final count, loaded on the REPORT entry edge.
  - If last_count > THRESH, alarm sets on the REPORT->next edge.
  - Rise and window counters are cleared; a rise in the REPORT cycle is not counted.
  - -> COUNT if enable=1 (back-to-back windows, one dead cycle), else -> IDLE.
- Alarm:
  - Sticky; only alarm_clr or reset clears it.
  - Set and alarm_clr in the same cycle: set wins.
  - alarm_clr has no effect on the counters or the FSM.
- Widths:
  - Window counter width is clog2(WINDOW).
  - The THRESH comparison is unsigned at CNT_W bits.
  - THRESH >= 2^CNT_W-1 means the alarm can never set; this is legal.

Decomposition:
- Shared package rew_pkg holds:
  - state enum: IDLE, ARM, COUNT, REPORT, 2-bit encoding 00/01/10/11;
  - the clog2 helper;
  - default constants for WINDOW, CNT_W and THRESH.
- One sub-module, rise_edge_det: the two-flop sample_q/sample_q_d path plus the rise output, with the same clock and synchronous reset.

Test Plan:
- Reset, then enable=1 with sample_in=0 for 40 cycles -> busy=1 from cycle 1; window_done pulses at cycles 18 and 35; last_count=0; alarm=0.
- Defaults; 4 isolated 1-cycle pulses on sample_in inside the first window -> window_done with last_count=4 and alarm=1 the next cycle; assert alarm_clr -> alarm=0.
- Exactly 3 pulses in a window -> last_count=3, alarm stays 0 (strict >).
- CNT_W=2, sample_in toggling every cycle for a full window -> last_count=3 (saturated, no wrap).
- enable dropped at the 10th COUNT cycle -> IDLE next cycle; no window_done; last_count keeps its previous value.
- Reset mid-window, and alarm_clr coinciding with an over-threshold REPORT:
  - reset -> all outputs 0 the following cycle;
  - alarm_clr case -> alarm remains 1.

Source files
------------

// File: rtl/rare_event_window_monitor_pkg.sv
// Shared types and defaults for the rare-event window monitor: FSM state
// encoding, default parameter values and a constant clog2 helper.
package rew_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARM    = 2'b01,
    COUNT  = 2'b10,
    REPORT = 2'b11
  } state_e;

  localparam int DEF_WINDOW = 16;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_THRESH = 3;

  // Bits needed to hold values 0..v-1; used for the window counter width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << r) < longint'(v)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rare_event_window_monitor_rise_edge_det.sv
// Two-flop sampler on the monitored net with a registered-only rise detector.
module rise_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sample_i,
  output logic rise_o
);

  logic sample_q;
  logic sample_q_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_q   <= 1'b0;
      sample_q_d <= 1'b0;
    end else begin
      sample_q   <= sample_i;
      sample_q_d <= sample_q;
    end
  end

  assign rise_o = sample_q & ~sample_q_d;

endmodule

// File: rtl/rare_event_window_monitor.sv
// Counts rising edges of one net over back-to-back fixed windows, reports each
// window's count and raises a sticky alarm when a count exceeds THRESH.
module rare_event_window_monitor
  import rew_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int THRESH = DEF_THRESH
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             sample_in,
  input  logic             enable,
  input  logic             alarm_clr,
  output logic             busy,
  output logic             window_done,
  output logic [CNT_W-1:0] last_count,
  output logic             alarm
);

  localparam int WIN_W = clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  // A threshold at or above the counter ceiling can never be exceeded.
  localparam bit NEVER_ALARM = (longint'(THRESH) >= ((longint'(1) << CNT_W) - 1));
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic inc);
    if (inc && (cnt != {CNT_W{1'b1}})) return cnt + 1'b1;
    return cnt;
  endfunction

  state_e           state_q;
  logic             busy_q;
  logic             wdone_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic [CNT_W-1:0] rise_cnt_q;
  logic [CNT_W-1:0] rise_cnt_d;
  logic [CNT_W-1:0] last_count_q;
  logic             alarm_q;
  logic             alarm_d;
  logic             alarm_set;
  logic             rise;

  rise_edge_det u_rise_edge_det (
    .clk_i    (I1470_clk),
    .rst_i    (I1477_rst),
    .sample_i (sample_in),
    .rise_o   (rise)
  );

  assign rise_cnt_d = sat_inc(rise_cnt_q, rise);
  assign alarm_set  = (state_q == REPORT) && !NEVER_ALARM && (last_count_q > THR);
  // Set dominates a simultaneous clear.
  assign alarm_d    = alarm_set | (alarm_q & ~alarm_clr);

  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      wdone_q      <= 1'b0;
      win_cnt_q    <= '0;
      rise_cnt_q   <= '0;
      last_count_q <= '0;
      alarm_q      <= 1'b0;
    end else begin
      wdone_q <= 1'b0;
      alarm_q <= alarm_d;
      case (state_q)
        IDLE: begin
          win_cnt_q  <= '0;
          rise_cnt_q <= '0;
          if (enable) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        ARM: begin
          win_cnt_q  <= '0;
          rise_cnt_q <= '0;
          if (enable) begin
            state_q <= COUNT;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        COUNT: begin
          if (!enable) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            win_cnt_q  <= '0;
            rise_cnt_q <= '0;
          end else if (win_cnt_q == WIN_LAST) begin
            state_q      <= REPORT;
            busy_q       <= 1'b1;
            wdone_q      <= 1'b1;
            last_count_q <= rise_cnt_d;
            win_cnt_q    <= '0;
            rise_cnt_q   <= '0;
          end else begin
            busy_q     <= 1'b1;
            win_cnt_q  <= win_cnt_q + 1'b1;
            rise_cnt_q <= rise_cnt_d;
          end
        end
        REPORT: begin
          win_cnt_q  <= '0;
          rise_cnt_q <= '0;
          if (enable) begin
            state_q <= COUNT;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign window_done = wdone_q;
  assign last_count  = last_count_q;
  assign alarm       = alarm_q;

endmodule

// File: tb/tb_rare_event_window_monitor.sv
// Directed bench for rare_event_window_monitor; a second instance with a
// 2-bit counter covers saturation.
module tb_rare_event_window_monitor;

  logic       clk;
  logic       rst;
  logic       sample_in;
  logic       enable;
  logic       alarm_clr;
  logic       busy, window_done, alarm;
  logic [7:0] last_count;
  logic       busy2, window_done2, alarm2;
  logic [1:0] last_count2;

  int          n_total;
  int          n_bad;
  int          cyc;
  logic [63:0] pat;

  rare_event_window_monitor #(.WINDOW(16), .CNT_W(8), .THRESH(3)) dut (
    .I1470_clk   (clk),
    .I1477_rst   (rst),
    .sample_in   (sample_in),
    .enable      (enable),
    .alarm_clr   (alarm_clr),
    .busy        (busy),
    .window_done (window_done),
    .last_count  (last_count),
    .alarm       (alarm)
  );

  rare_event_window_monitor #(.WINDOW(16), .CNT_W(2), .THRESH(3)) dut_sat (
    .I1470_clk   (clk),
    .I1477_rst   (rst),
    .sample_in   (sample_in),
    .enable      (enable),
    .alarm_clr   (alarm_clr),
    .busy        (busy2),
    .window_done (window_done2),
    .last_count  (last_count2),
    .alarm       (alarm2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // Advance to the given cycle index; sample_in in cycle c is pat[c].
  task automatic adv_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
      sample_in = (cyc < 64) ? pat[cyc] : 1'b0;
    end
  endtask

  // Reset for two edges, then start a run with cycle 0 in IDLE and enable=1.
  task automatic do_reset();
    rst       = 1'b1;
    enable    = 1'b0;
    alarm_clr = 1'b0;
    sample_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst       = 1'b0;
    cyc       = 0;
    enable    = 1'b1;
    sample_in = pat[0];
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    cyc     = 0;

    // Idle input: windows report 0 at cycles 18 and 35.
    pat = '0;
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", window_done, 0);
    chk("rst_cnt", last_count, 0);
    chk("rst_alarm", alarm, 0);
    for (int c = 1; c <= 40; c++) begin
      adv_to(c);
      chk("t1_busy", busy, 1);
      chk("t1_done", window_done, (c == 18 || c == 35) ? 1 : 0);
    end
    chk("t1_cnt", last_count, 0);
    chk("t1_alarm", alarm, 0);

    // Four isolated pulses exceed THRESH=3; then clear the alarm.
    pat = '0;
    pat[3] = 1'b1; pat[6] = 1'b1; pat[9] = 1'b1; pat[12] = 1'b1;
    do_reset();
    adv_to(17);
    chk("t2_done17", window_done, 0);
    adv_to(18);
    chk("t2_done18", window_done, 1);
    chk("t2_cnt", last_count, 4);
    chk("t2_alarm18", alarm, 0);
    adv_to(19);
    chk("t2_alarm19", alarm, 1);
    chk("t2_done19", window_done, 0);
    alarm_clr = 1'b1;
    adv_to(20);
    alarm_clr = 1'b0;
    chk("t2_clr", alarm, 0);
    chk("t2_busy", busy, 1);

    // Exactly three pulses: no alarm.
    pat = '0;
    pat[3] = 1'b1; pat[6] = 1'b1; pat[9] = 1'b1;
    do_reset();
    adv_to(18);
    chk("t3_done", window_done, 1);
    chk("t3_cnt", last_count, 3);
    adv_to(19);
    chk("t3_alarm", alarm, 0);

    // Toggle every cycle: 8 rises, 2-bit instance saturates at 3.
    pat = 64'hAAAA_AAAA_AAAA_AAAA;
    do_reset();
    adv_to(18);
    chk("t4_done", window_done, 1);
    chk("t4_cnt", last_count, 8);
    chk("t4_sat_done", window_done2, 1);
    chk("t4_sat_cnt", last_count2, 3);
    adv_to(19);
    chk("t4_alarm", alarm, 1);
    chk("t4_sat_alarm", alarm2, 0);

    // Drop enable in the 10th COUNT cycle of the second window (cycle 28).
    adv_to(28);
    chk("t5_busy28", busy, 1);
    enable = 1'b0;
    adv_to(29);
    chk("t5_busy29", busy, 0);
    for (int c = 30; c <= 40; c++) begin
      adv_to(c);
      chk("t5_done", window_done, 0);
    end
    chk("t5_cnt", last_count, 8);
    chk("t5_sat_cnt", last_count2, 3);
    chk("t5_idle_busy", busy, 0);

    // Reset in mid-window after an alarm clears everything.
    pat = '0;
    pat[3] = 1'b1; pat[6] = 1'b1; pat[9] = 1'b1; pat[12] = 1'b1;
    pat[22] = 1'b1;
    do_reset();
    adv_to(25);
    chk("t6_pre_alarm", alarm, 1);
    chk("t6_pre_cnt", last_count, 4);
    rst = 1'b1;
    adv_to(26);
    rst = 1'b0;
    enable = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_done", window_done, 0);
    chk("t6_cnt", last_count, 0);
    chk("t6_alarm", alarm, 0);

    // alarm_clr in the over-threshold REPORT cycle: set wins.
    do_reset();
    adv_to(18);
    chk("t7_done", window_done, 1);
    alarm_clr = 1'b1;
    adv_to(19);
    alarm_clr = 1'b0;
    chk("t7_alarm", alarm, 1);
    adv_to(21);
    chk("t7_hold", alarm, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
